// File: rtl/alk_flag_rdmux_if.sv
// Flag-readout bus bundle: producer-side flag inputs, the read request
// and the registered WBUS drive back out of the flag block.
interface alk_flag_rdmux_if #(
  parameter int WIDTH  = 2,
  parameter int NGROUP = 2,
  parameter int GSEL_W = (NGROUP > 1) ? $clog2(NGROUP) : 1
) ();
  localparam int NFLAG = WIDTH * NGROUP;

  logic [NFLAG-1:0]  flag_in_h;
  logic [NFLAG-1:0]  flag_ld_h;
  logic              rd_req_h;
  logic [GSEL_W-1:0] rd_grp_h;
  logic              rd_clr_h;
  logic [NFLAG-1:0]  flags_h;
  logic [31:0]       wbus_out_h;
  logic [31:0]       wbus_oe_h;
  logic              rd_vld_h;

  modport master (
    output flag_in_h, flag_ld_h, rd_req_h, rd_grp_h, rd_clr_h,
    input  flags_h, wbus_out_h, wbus_oe_h, rd_vld_h
  );

  modport slave (
    input  flag_in_h, flag_ld_h, rd_req_h, rd_grp_h, rd_clr_h,
    output flags_h, wbus_out_h, wbus_oe_h, rd_vld_h
  );
endinterface

// File: rtl/alk_flag_rdmux.sv
// Flag register bank with per-flag capture/sticky control and a registered
// one-cycle readout of one selected group onto the WBUS.
module alk_flag_rdmux #(
  parameter int WIDTH    = 2,
  parameter int NGROUP   = 2,
  parameter int WBUS_LSB = 30,
  parameter logic [WIDTH*NGROUP-1:0] STICKY_MASK = '0,
  parameter int GSEL_W   = (NGROUP > 1) ? $clog2(NGROUP) : 1
) (
  input  logic                clk_h,
  input  logic                reset_l,
  alk_flag_rdmux_if.slave     bus,
  output logic                dbg_state_o
);
  localparam int NFLAG = WIDTH * NGROUP;

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [NFLAG-1:0] flags_q, flags_d;
  logic [NFLAG-1:0] clr_mask;

  // Handshake: a request is accepted on every edge it is high (no ready);
  // rd_vld_h is high exactly in the cycle after each accepted request.
  always_comb begin
    snap_d   = '0;
    clr_mask = '0;
    state_d  = IDLE;
    if (bus.rd_req_h) begin
      state_d = DRIVE;
      // Out-of-range groups match nothing: zero snapshot, no clear.
      for (int g = 0; g < NGROUP; g++) begin
        if (bus.rd_grp_h == GSEL_W'(g)) begin
          snap_d = flags_q[g*WIDTH +: WIDTH];
          if (bus.rd_clr_h) clr_mask[g*WIDTH +: WIDTH] = '1;
        end
      end
    end
  end

  // Capture beats clear; sticky flags OR new events onto the surviving value.
  always_comb begin
    flags_d = (flags_q & ~clr_mask & ~bus.flag_ld_h)
            | (bus.flag_ld_h & bus.flag_in_h)
            | (bus.flag_ld_h & STICKY_MASK & flags_q & ~clr_mask);
  end

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      snap_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    bus.wbus_out_h = '0;
    bus.wbus_oe_h  = '0;
    bus.rd_vld_h   = 1'b0;
    if (state_q == DRIVE) begin
      bus.wbus_out_h = 32'(snap_q) << WBUS_LSB;
      bus.wbus_oe_h  = 32'({WIDTH{1'b1}}) << WBUS_LSB;
      bus.rd_vld_h   = 1'b1;
    end
  end

  assign bus.flags_h  = flags_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_alk_flag_rdmux.sv
// Bench for alk_flag_rdmux: three instances (defaults, sticky low group,
// WIDTH=4/NGROUP=3) checked against an expected-drive queue.
module tb_alk_flag_rdmux;
  logic clk_h;
  logic reset_l;
  logic dbg_a, dbg_s, dbg_p;

  int n_cmp = 0;
  int n_err = 0;
  logic [64:0] exp_q[$];
  logic [64:0] got, exp_v;

  alk_flag_rdmux_if #(.WIDTH(2), .NGROUP(2)) a_if ();
  alk_flag_rdmux_if #(.WIDTH(2), .NGROUP(2)) s_if ();
  alk_flag_rdmux_if #(.WIDTH(4), .NGROUP(3)) p_if ();

  alk_flag_rdmux u_a (.clk_h(clk_h), .reset_l(reset_l), .bus(a_if), .dbg_state_o(dbg_a));
  alk_flag_rdmux #(.STICKY_MASK(4'b0011)) u_s (
    .clk_h(clk_h), .reset_l(reset_l), .bus(s_if), .dbg_state_o(dbg_s));
  alk_flag_rdmux #(.WIDTH(4), .NGROUP(3), .WBUS_LSB(28)) u_p (
    .clk_h(clk_h), .reset_l(reset_l), .bus(p_if), .dbg_state_o(dbg_p));

  // clock / reset
  initial clk_h = 1'b0;
  always #5 clk_h = ~clk_h;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic idle_all();
    a_if.flag_in_h = '0; a_if.flag_ld_h = '0; a_if.rd_req_h = 0; a_if.rd_grp_h = '0; a_if.rd_clr_h = 0;
    s_if.flag_in_h = '0; s_if.flag_ld_h = '0; s_if.rd_req_h = 0; s_if.rd_grp_h = '0; s_if.rd_clr_h = 0;
    p_if.flag_in_h = '0; p_if.flag_ld_h = '0; p_if.rd_req_h = 0; p_if.rd_grp_h = '0; p_if.rd_clr_h = 0;
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    idle_all();
    a_if.flag_in_h = 4'hF; a_if.flag_ld_h = 4'hF; a_if.rd_req_h = 1;
    tick(); tick();
    n_cmp++;
    if (a_if.flags_h !== 4'h0) begin n_err++; $display("FAIL reset_flags: got %h required 0", a_if.flags_h); end
    n_cmp++;
    if (a_if.wbus_oe_h !== 32'h0 || a_if.rd_vld_h !== 1'b0 || a_if.wbus_out_h !== 32'h0) begin
      n_err++; $display("FAIL reset_outputs: got oe=%h vld=%b out=%h required 0", a_if.wbus_oe_h, a_if.rd_vld_h, a_if.wbus_out_h);
    end
    idle_all();
    reset_l = 1'b1;
    tick();
    // reset during a drive cycle must kill it before the next edge
    a_if.rd_req_h = 1;
    tick();
    a_if.rd_req_h = 0;
    n_cmp++;
    if (a_if.rd_vld_h !== 1'b1) begin n_err++; $display("FAIL reset_pre_drive: got vld=%b required 1", a_if.rd_vld_h); end
    #2 reset_l = 1'b0;
    #1;
    n_cmp++;
    if (a_if.rd_vld_h !== 1'b0 || a_if.wbus_oe_h !== 32'h0 || a_if.wbus_out_h !== 32'h0) begin
      n_err++; $display("FAIL reset_mid_drive: got vld=%b oe=%h out=%h required 0", a_if.rd_vld_h, a_if.wbus_oe_h, a_if.wbus_out_h);
    end
    #1 reset_l = 1'b1;
    tick();
  endtask

  task automatic test_basic_read();
    a_if.flag_in_h = 4'b1001; a_if.flag_ld_h = 4'hF;
    tick();
    a_if.flag_ld_h = 4'h0;
    n_cmp++;
    if (a_if.flags_h !== 4'b1001) begin n_err++; $display("FAIL basic_load: got %b required 1001", a_if.flags_h); end
    a_if.rd_req_h = 1; a_if.rd_grp_h = 1'b0;
    exp_q.push_back({1'b1, 32'hC000_0000, 32'h4000_0000});
    tick();
    a_if.rd_req_h = 0;
    got = {a_if.rd_vld_h, a_if.wbus_oe_h, a_if.wbus_out_h};
    n_cmp++;
    if (exp_q.size() == 0) begin n_err++; $display("FAIL basic_drive: queue empty, got %h", got); end
    else begin
      exp_v = exp_q.pop_front();
      if (got !== exp_v) begin n_err++; $display("FAIL basic_drive: got %h required %h", got, exp_v); end
    end
    tick();
    n_cmp++;
    if (a_if.rd_vld_h !== 1'b0 || a_if.wbus_oe_h !== 32'h0 || a_if.wbus_out_h !== 32'h0) begin
      n_err++; $display("FAIL basic_idle: got vld=%b oe=%h out=%h required 0", a_if.rd_vld_h, a_if.wbus_oe_h, a_if.wbus_out_h);
    end
  endtask

  task automatic test_back_to_back();
    a_if.flag_in_h = 4'b0110; a_if.flag_ld_h = 4'hF;
    tick();
    a_if.flag_ld_h = 4'h0;
    a_if.rd_req_h = 1; a_if.rd_grp_h = 1'b0;
    exp_q.push_back({1'b1, 32'hC000_0000, 32'h8000_0000});
    tick();
    got = {a_if.rd_vld_h, a_if.wbus_oe_h, a_if.wbus_out_h};
    a_if.rd_grp_h = 1'b1;
    exp_q.push_back({1'b1, 32'hC000_0000, 32'h4000_0000});
    n_cmp++;
    exp_v = exp_q.pop_front();
    if (got !== exp_v) begin n_err++; $display("FAIL b2b_grp0: got %h required %h", got, exp_v); end
    tick();
    a_if.rd_req_h = 0;
    got = {a_if.rd_vld_h, a_if.wbus_oe_h, a_if.wbus_out_h};
    n_cmp++;
    exp_v = exp_q.pop_front();
    if (got !== exp_v) begin n_err++; $display("FAIL b2b_grp1: got %h required %h", got, exp_v); end
    tick();
    n_cmp++;
    if (a_if.rd_vld_h !== 1'b0) begin n_err++; $display("FAIL b2b_end: got vld=%b required 0", a_if.rd_vld_h); end
  endtask

  task automatic test_sticky();
    s_if.flag_ld_h = 4'hF; s_if.flag_in_h = 4'b0101;
    tick();
    s_if.flag_in_h = 4'b1010;
    tick();
    n_cmp++;
    if (s_if.flags_h !== 4'b1011) begin n_err++; $display("FAIL sticky_accum: got %b required 1011", s_if.flags_h); end
    s_if.flag_in_h = 4'b0000;
    tick();
    s_if.flag_ld_h = 4'h0;
    n_cmp++;
    if (s_if.flags_h !== 4'b0011) begin n_err++; $display("FAIL sticky_zero_load: got %b required 0011", s_if.flags_h); end
  endtask

  task automatic test_read_clear();
    // flags are 0011 here; clear races a capture on bit 0
    s_if.rd_req_h = 1; s_if.rd_grp_h = 1'b0; s_if.rd_clr_h = 1;
    s_if.flag_ld_h = 4'b0001; s_if.flag_in_h = 4'b0001;
    exp_q.push_back({1'b1, 32'hC000_0000, 32'hC000_0000});
    tick();
    idle_all();
    got = {s_if.rd_vld_h, s_if.wbus_oe_h, s_if.wbus_out_h};
    n_cmp++;
    exp_v = exp_q.pop_front();
    if (got !== exp_v) begin n_err++; $display("FAIL rdclr_race_drive: got %h required %h", got, exp_v); end
    n_cmp++;
    if (s_if.flags_h !== 4'b0001) begin n_err++; $display("FAIL rdclr_race_flags: got %b required 0001", s_if.flags_h); end
    s_if.flag_ld_h = 4'b0011; s_if.flag_in_h = 4'b0011;
    tick();
    s_if.flag_ld_h = 4'h0; s_if.flag_in_h = 4'h0;
    s_if.rd_req_h = 1; s_if.rd_grp_h = 1'b0; s_if.rd_clr_h = 1;
    exp_q.push_back({1'b1, 32'hC000_0000, 32'hC000_0000});
    tick();
    idle_all();
    got = {s_if.rd_vld_h, s_if.wbus_oe_h, s_if.wbus_out_h};
    n_cmp++;
    exp_v = exp_q.pop_front();
    if (got !== exp_v) begin n_err++; $display("FAIL rdclr_drive: got %h required %h", got, exp_v); end
    n_cmp++;
    if (s_if.flags_h !== 4'b0000) begin n_err++; $display("FAIL rdclr_flags: got %b required 0000", s_if.flags_h); end
    // clear without request is ignored
    s_if.flag_ld_h = 4'hF; s_if.flag_in_h = 4'b1100;
    tick();
    s_if.flag_ld_h = 4'h0; s_if.rd_clr_h = 1; s_if.rd_grp_h = 1'b1;
    tick();
    s_if.rd_clr_h = 0;
    n_cmp++;
    if (s_if.flags_h !== 4'b1100 || s_if.rd_vld_h !== 1'b0) begin
      n_err++; $display("FAIL clr_no_req: got flags=%b vld=%b required 1100/0", s_if.flags_h, s_if.rd_vld_h);
    end
  endtask

  task automatic test_param_groups();
    p_if.flag_ld_h = 12'hFFF; p_if.flag_in_h = 12'hABC;
    tick();
    p_if.flag_ld_h = 12'h0;
    p_if.rd_req_h = 1; p_if.rd_grp_h = 2'd3; p_if.rd_clr_h = 1;
    exp_q.push_back({1'b1, 32'hF000_0000, 32'h0000_0000});
    tick();
    p_if.rd_grp_h = 2'd1; p_if.rd_clr_h = 0;
    exp_q.push_back({1'b1, 32'hF000_0000, 32'hB000_0000});
    got = {p_if.rd_vld_h, p_if.wbus_oe_h, p_if.wbus_out_h};
    n_cmp++;
    exp_v = exp_q.pop_front();
    if (got !== exp_v) begin n_err++; $display("FAIL param_oob_drive: got %h required %h", got, exp_v); end
    n_cmp++;
    if (p_if.flags_h !== 12'hABC) begin n_err++; $display("FAIL param_oob_noclr: got %h required abc", p_if.flags_h); end
    tick();
    p_if.rd_grp_h = 2'd2; p_if.rd_clr_h = 1;
    exp_q.push_back({1'b1, 32'hF000_0000, 32'hA000_0000});
    got = {p_if.rd_vld_h, p_if.wbus_oe_h, p_if.wbus_out_h};
    n_cmp++;
    exp_v = exp_q.pop_front();
    if (got !== exp_v) begin n_err++; $display("FAIL param_grp1: got %h required %h", got, exp_v); end
    tick();
    idle_all();
    got = {p_if.rd_vld_h, p_if.wbus_oe_h, p_if.wbus_out_h};
    n_cmp++;
    exp_v = exp_q.pop_front();
    if (got !== exp_v) begin n_err++; $display("FAIL param_grp2: got %h required %h", got, exp_v); end
    n_cmp++;
    if (p_if.flags_h !== 12'h0BC) begin n_err++; $display("FAIL param_grp2_clr: got %h required 0bc", p_if.flags_h); end
  endtask

  task automatic test_random_reads();
    logic [3:0] f;
    logic       g;
    for (int i = 0; i < 8; i++) begin
      f = 4'($urandom_range(0, 15));
      g = 1'($urandom_range(0, 1));
      a_if.flag_ld_h = 4'hF; a_if.flag_in_h = f;
      tick();
      a_if.flag_ld_h = 4'h0;
      a_if.rd_req_h = 1; a_if.rd_grp_h = g;
      exp_q.push_back({1'b1, 32'hC000_0000, {(g ? f[3:2] : f[1:0]), 30'h0}});
      tick();
      a_if.rd_req_h = 0;
      got = {a_if.rd_vld_h, a_if.wbus_oe_h, a_if.wbus_out_h};
      n_cmp++;
      exp_v = exp_q.pop_front();
      if (got !== exp_v) begin n_err++; $display("FAIL rand_read_%0d: got %h required %h", i, got, exp_v); end
    end
  endtask

  initial begin
    idle_all();
    reset_l = 1'b0;
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_sticky();
    test_read_clear();
    test_param_groups();
    test_random_reads();
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL queue_drain: got %0d left required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
